// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/update sequencer issuing one PC load per retired instruction.
// Minimum latency 4 cycles (F,D,E,U); stalls in FETCH/EXEC/MEM until ack/done, fetch stall bounded by FETCH_TIMEOUT.
module pc_sequencer #(
    parameter int unsigned FETCH_TIMEOUT = 1023,
    parameter int unsigned TIMEOUT_W     = 10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_PC,
    output logic        o_fetch_req,
    output logic [31:0] o_fetch_addr,
    input  logic        i_fetch_ack,
    input  logic [31:0] i_fetch_data,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    input  logic        i_exec_done,
    input  logic        i_mem_op,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    output logic        o_mem_start,
    input  logic        i_mem_done,
    input  logic        i_trap,
    input  logic [31:0] i_trap_vector,
    output logic        o_load_PC,
    output logic        o_jump_DV,
    output logic [31:0] o_jump_address,
    output logic        o_fault,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_UPDATE = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [TIMEOUT_W-1:0] LP_LIMIT = TIMEOUT_W'(FETCH_TIMEOUT);
    localparam bit                   LP_TO_EN = (FETCH_TIMEOUT != 0);

    state_t               r_state;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic [31:0]          r_instr;
    logic                 r_instr_valid;
    logic                 r_fetch_req;
    logic                 r_mem_start;
    logic                 r_load_pc;
    logic                 r_jump_dv;
    logic [31:0]          r_jump_addr;
    logic                 r_taken;
    logic [31:0]          r_target;
    logic                 r_fault;

    logic [31:0] w_trap_tgt;
    logic [31:0] w_exec_tgt;

    // Redirect targets are always word aligned.
    assign w_trap_tgt = {i_trap_vector[31:2], 2'b00};
    assign w_exec_tgt = {i_branch_target[31:2], 2'b00};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_RESET;
            r_cnt         <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_fetch_req   <= 1'b0;
            r_mem_start   <= 1'b0;
            r_load_pc     <= 1'b0;
            r_jump_dv     <= 1'b0;
            r_jump_addr   <= '0;
            r_taken       <= 1'b0;
            r_target      <= '0;
            r_fault       <= 1'b0;
        end else begin
            r_instr_valid <= 1'b0;
            r_mem_start   <= 1'b0;
            r_load_pc     <= 1'b0;
            r_jump_dv     <= 1'b0;
            r_jump_addr   <= '0;
            case (r_state)
                S_RESET: begin
                    r_state     <= S_FETCH;
                    r_fetch_req <= 1'b1;
                end
                S_FETCH: begin
                    // An ack on the limit cycle takes priority over the timeout.
                    if (i_fetch_ack) begin
                        r_instr       <= i_fetch_data;
                        r_cnt         <= '0;
                        r_fetch_req   <= 1'b0;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_DECODE;
                    end else if (LP_TO_EN && (r_cnt == LP_LIMIT)) begin
                        r_fetch_req <= 1'b0;
                        r_fault     <= 1'b1;
                        r_state     <= S_HALT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (i_trap) begin
                        r_taken     <= 1'b1;
                        r_target    <= w_trap_tgt;
                        r_load_pc   <= 1'b1;
                        r_jump_dv   <= 1'b1;
                        r_jump_addr <= w_trap_tgt;
                        r_state     <= S_UPDATE;
                    end else if (i_exec_done) begin
                        r_taken  <= i_branch_taken;
                        r_target <= w_exec_tgt;
                        if (i_mem_op) begin
                            r_mem_start <= 1'b1;
                            r_state     <= S_MEM;
                        end else begin
                            r_load_pc   <= 1'b1;
                            r_jump_dv   <= i_branch_taken;
                            r_jump_addr <= w_exec_tgt;
                            r_state     <= S_UPDATE;
                        end
                    end
                end
                S_MEM: begin
                    if (i_trap) begin
                        r_taken     <= 1'b1;
                        r_target    <= w_trap_tgt;
                        r_load_pc   <= 1'b1;
                        r_jump_dv   <= 1'b1;
                        r_jump_addr <= w_trap_tgt;
                        r_state     <= S_UPDATE;
                    end else if (i_mem_done) begin
                        r_load_pc   <= 1'b1;
                        r_jump_dv   <= r_taken;
                        r_jump_addr <= r_target;
                        r_state     <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_fetch_req <= 1'b1;
                    r_state     <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_fetch_req <= 1'b0;
                    r_state     <= S_RESET;
                end
            endcase
        end
    end

    // The PC register loads on the UPDATE edge, so the fetch address must track i_PC live.
    assign o_fetch_addr   = r_fetch_req ? i_PC : 32'd0;
    assign o_fetch_req    = r_fetch_req;
    assign o_instr        = r_instr;
    assign o_instr_valid  = r_instr_valid;
    assign o_mem_start    = r_mem_start;
    assign o_load_PC      = r_load_pc;
    assign o_jump_DV      = r_jump_dv;
    assign o_jump_address = r_jump_addr;
    assign o_fault        = r_fault;
    assign o_state        = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: table of instruction scenarios, randomized instructions, reset and timeout sequences.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_init;
    logic        o_fetch_req;
    logic [31:0] o_fetch_addr;
    logic        i_fetch_ack;
    logic [31:0] i_fetch_data;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic        i_exec_done;
    logic        i_mem_op;
    logic        i_branch_taken;
    logic [31:0] i_branch_target;
    logic        o_mem_start;
    logic        i_mem_done;
    logic        i_trap;
    logic [31:0] i_trap_vector;
    logic        o_load_PC;
    logic        o_jump_DV;
    logic [31:0] o_jump_address;
    logic        o_fault;
    logic [2:0]  o_state;

    always #5 clk = ~clk;

    pc_sequencer #(.FETCH_TIMEOUT(8), .TIMEOUT_W(10)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_PC(pc),
        .o_fetch_req(o_fetch_req), .o_fetch_addr(o_fetch_addr),
        .i_fetch_ack(i_fetch_ack), .i_fetch_data(i_fetch_data),
        .o_instr(o_instr), .o_instr_valid(o_instr_valid),
        .i_exec_done(i_exec_done), .i_mem_op(i_mem_op),
        .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
        .o_mem_start(o_mem_start), .i_mem_done(i_mem_done),
        .i_trap(i_trap), .i_trap_vector(i_trap_vector),
        .o_load_PC(o_load_PC), .o_jump_DV(o_jump_DV), .o_jump_address(o_jump_address),
        .o_fault(o_fault), .o_state(o_state)
    );

    // Program counter that the sequencer controls.
    always @(posedge clk) begin
        if (pc_init) pc <= 32'h8000_0000;
        else if (o_load_PC) pc <= o_jump_DV ? o_jump_address : pc + 32'd4;
    end

    int cyc = 0;
    int nload = 0;
    int nmst = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_load_PC) nload <= nload + 1;
        if (o_mem_start) nmst <= nmst + 1;
    end

    int nvec = 0;
    int nerr = 0;
    int exp_nload = 0;
    int exp_nmst = 0;
    logic [31:0] m_pc;

    typedef struct {
        int          df, de, dm;
        bit          mem, tk, trp_e, trp_m, noise;
        logic [31:0] tgt, vec, data;
        bit          x_jump;
        logic [31:0] x_addr;
        int          x_lat;
        bit          x_mem;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int df, de, dm, input bit mem, tk, te, tm, noise,
                                input logic [31:0] tgt, vec, data,
                                input bit xj, input logic [31:0] xa, input int xl, input bit xm);
        vec_t v;
        v.df = df; v.de = de; v.dm = dm;
        v.mem = mem; v.tk = tk; v.trp_e = te; v.trp_m = tm; v.noise = noise;
        v.tgt = tgt; v.vec = vec; v.data = data;
        v.x_jump = xj; v.x_addr = xa; v.x_lat = xl; v.x_mem = xm;
        return v;
    endfunction

    // Instruction-level reference: what retires, where it goes, and how long it takes.
    function automatic vec_t mk_rand();
        vec_t v;
        int   r;
        bit   trap;
        v.df = int'($urandom_range(0, 8));
        v.de = int'($urandom_range(0, 3));
        v.dm = int'($urandom_range(0, 3));
        v.mem = ($urandom_range(0, 1) == 1);
        v.tk = ($urandom_range(0, 1) == 1);
        r = int'($urandom_range(0, 9));
        v.trp_e = (r == 0);
        v.trp_m = (r == 1) && v.mem;
        v.noise = ($urandom_range(0, 3) == 0);
        v.tgt = $urandom;
        v.vec = $urandom;
        v.data = $urandom;
        trap = v.trp_e || v.trp_m;
        v.x_jump = trap || v.tk;
        v.x_addr = (trap ? v.vec : v.tgt) & 32'hFFFF_FFFC;
        v.x_mem = v.mem && !v.trp_e;
        v.x_lat = (v.df + 1) + 1 + (v.de + 1) + (v.x_mem ? v.dm + 1 : 0) + 1;
        return v;
    endfunction

    task automatic clear_in;
        i_fetch_ack = 1'b0; i_exec_done = 1'b0; i_mem_op = 1'b0; i_branch_taken = 1'b0;
        i_mem_done = 1'b0; i_trap = 1'b0;
        i_branch_target = $urandom; i_trap_vector = $urandom; i_fetch_data = $urandom;
    endtask

    // Entered at the first FETCH cycle; leaves at the first FETCH cycle of the next instruction.
    task automatic run(input vec_t v);
        int t0;
        bit seen;
        chk("fetch_state", 32'(o_state), 32'd1);
        chk("fetch_req", 32'(o_fetch_req), 32'd1);
        chk("fetch_addr", o_fetch_addr, m_pc);
        t0 = cyc;
        i_trap = v.noise;
        repeat (v.df) step;
        i_fetch_ack = 1'b1; i_fetch_data = v.data;
        step;
        i_fetch_ack = 1'b0; i_fetch_data = $urandom;
        chk("decode_valid", 32'(o_instr_valid), 32'd1);
        chk("decode_instr", o_instr, v.data);
        step;
        i_trap = 1'b0;
        chk("exec_valid_off", 32'(o_instr_valid), 32'd0);
        repeat (v.de) step;
        i_exec_done = 1'b1; i_mem_op = v.mem; i_branch_taken = v.tk;
        i_branch_target = v.tgt; i_trap = v.trp_e; i_trap_vector = v.vec;
        step;
        clear_in();
        i_trap_vector = v.vec;
        chk("mem_start", 32'(o_mem_start), 32'(v.x_mem));
        if (v.mem && !v.trp_e) begin
            repeat (v.dm) begin
                step;
                chk("mem_start_once", 32'(o_mem_start), 32'd0);
            end
            if (v.trp_m) i_trap = 1'b1;
            else i_mem_done = 1'b1;
            step;
            i_trap = 1'b0; i_mem_done = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (o_load_PC) begin
                seen = 1'b1;
                break;
            end
            step;
        end
        chk("load_seen", 32'(seen), 32'd1);
        chk("latency", 32'(cyc - t0 + 1), 32'(v.x_lat));
        chk("jump_dv", 32'(o_jump_DV), 32'(v.x_jump));
        chk("jump_addr", o_jump_address, v.x_addr);
        m_pc = v.x_jump ? v.x_addr : m_pc + 32'd4;
        exp_nload++;
        if (v.x_mem) exp_nmst++;
        step;
        chk("jump_dv_off", 32'(o_jump_DV), 32'd0);
    endtask

    initial begin
        bit   seen;
        int   saved;
        vec_t rv;
        //        df de dm mem tk te tm nz  tgt            vec            data          xj xa             lat xm
        tbl[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0013, 0, 32'h0,         4,  0);
        tbl[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0010_0093, 0, 32'h0,         4,  0);
        tbl[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0020_0113, 0, 32'h0,         4,  0);
        tbl[3] = mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h8000_0103, 32'h0,         32'h0000_006F, 1, 32'h8000_0100, 4,  0);
        tbl[4] = mk(0, 0, 2, 1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_2003, 0, 32'h0,         7,  1);
        tbl[5] = mk(0, 0, 0, 1, 1, 1, 0, 0, 32'h1234_5678, 32'h8000_1000, 32'h0000_0073, 1, 32'h8000_1000, 4,  0);
        tbl[6] = mk(1, 2, 1, 1, 0, 0, 1, 0, 32'h0,         32'h8000_2002, 32'h0000_2023, 1, 32'h8000_2000, 9,  1);
        tbl[7] = mk(8, 0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0033, 0, 32'h0,         12, 0);
        tbl[8] = mk(2, 1, 0, 0, 0, 0, 0, 1, 32'h0,         32'h0,         32'h0000_00B3, 0, 32'h0,         7,  0);
        tbl[9] = mk(0, 0, 0, 1, 1, 0, 0, 0, 32'h8000_0201, 32'h0,         32'h0000_0063, 1, 32'h8000_0200, 5,  1);

        rst_n = 1'b0; pc_init = 1'b1;
        clear_in();
        repeat (3) step;
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_fetch_req", 32'(o_fetch_req), 32'd0);
        chk("rst_load", 32'(o_load_PC), 32'd0);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_fault", 32'(o_fault), 32'd0);
        chk("rst_jump_addr", o_jump_address, 32'd0);
        pc_init = 1'b0; rst_n = 1'b1;
        m_pc = 32'h8000_0000;
        step;

        for (int i = 0; i < 10; i++) run(tbl[i]);
        for (int i = 0; i < 40; i++) begin
            rv = mk_rand();
            run(rv);
        end

        // Reset landing in the middle of a memory phase.
        chk("mrst_fetch_addr", o_fetch_addr, m_pc);
        i_fetch_ack = 1'b1; step; i_fetch_ack = 1'b0;
        step;
        i_exec_done = 1'b1; i_mem_op = 1'b1; i_branch_taken = 1'b1; i_branch_target = 32'h8000_0400;
        step;
        clear_in();
        chk("mrst_mem_start", 32'(o_mem_start), 32'd1);
        exp_nmst++;
        step;
        rst_n = 1'b0; i_mem_done = 1'b1;
        step;
        rst_n = 1'b1; i_mem_done = 1'b0;
        chk("mrst_state", 32'(o_state), 32'd0);
        chk("mrst_load", 32'(o_load_PC), 32'd0);
        chk("mrst_fetch_req", 32'(o_fetch_req), 32'd0);
        chk("mrst_fetch_addr0", o_fetch_addr, 32'd0);
        chk("mrst_instr", o_instr, 32'd0);
        chk("mrst_mem_start0", 32'(o_mem_start), 32'd0);
        chk("mrst_jump", 32'(o_jump_DV), 32'd0);
        chk("mrst_nload", 32'(nload), 32'(exp_nload));
        step;
        chk("mrst_refetch_state", 32'(o_state), 32'd1);
        run(tbl[0]);

        // Fetch timeout: 8 unacknowledged cycles allowed, the 9th without ack faults.
        repeat (8) step;
        chk("to_still_fetch", 32'(o_state), 32'd1);
        chk("to_no_fault_yet", 32'(o_fault), 32'd0);
        step;
        chk("to_halt", 32'(o_state), 32'd6);
        chk("to_fault", 32'(o_fault), 32'd1);
        chk("to_req_off", 32'(o_fetch_req), 32'd0);
        saved = nload;
        seen = 1'b0;
        i_fetch_ack = 1'b1; i_trap = 1'b1; i_exec_done = 1'b1; i_mem_done = 1'b1;
        repeat (10) begin
            step;
            seen = seen | o_fetch_req | o_load_PC | o_mem_start;
        end
        clear_in();
        chk("halt_quiet", 32'(seen), 32'd0);
        chk("halt_state", 32'(o_state), 32'd6);
        chk("halt_fault_sticky", 32'(o_fault), 32'd1);
        chk("halt_nload", 32'(nload), 32'(saved));
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        chk("halt_rst_fault", 32'(o_fault), 32'd0);
        chk("halt_rst_state", 32'(o_state), 32'd0);
        step;
        chk("halt_rst_fetch", 32'(o_state), 32'd1);
        chk("halt_rst_addr", o_fetch_addr, m_pc);

        chk("total_loads", 32'(nload), 32'(exp_nload));
        chk("total_mem_starts", 32'(nmst), 32'(exp_nmst));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
